// File: rtl/resource_branch_mo.sv
// resource_branch_mo: multi-outstanding resource request issuer with in-order response tracker
// Ports: in_* request from dispatch, req_* request to resource port, rsp_* in-order response,
//        block/dest/commit_id/result_out + out_is_write beat to commit, outstanding occupancy,
//        protocol_err sticky response-with-empty-tracker flag.
module resource_branch_mo #(
    parameter int DATA_WIDTH    = 16,
    parameter int HANDLE_WIDTH  = 8,
    parameter int N_BLOCKS      = 256,
    parameter int DEPTH         = 4,
    parameter int CID_WIDTH     = 8,
    parameter bit SIGN_EXTEND   = 1,
    parameter bit WRITE_ACK_OUT = 0,
    localparam int BW = $clog2(N_BLOCKS),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    write_in,
    input  logic [BW-1:0]           block_in,
    input  logic [HANDLE_WIDTH-1:0] handle_in,
    input  logic [DATA_WIDTH-1:0]   arg_a_in,
    input  logic [DATA_WIDTH-1:0]   arg_b_in,
    input  logic [3:0]              dest_in,
    input  logic [CID_WIDTH-1:0]    commit_id_in,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_write,
    output logic [HANDLE_WIDTH-1:0] req_handle,
    output logic [DATA_WIDTH-1:0]   req_arg_a,
    output logic [DATA_WIDTH-1:0]   req_arg_b,
    input  logic                    rsp_valid,
    output logic                    rsp_ready,
    input  logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BW-1:0]           block_out,
    output logic [3:0]              dest_out,
    output logic [CID_WIDTH-1:0]    commit_id_out,
    output logic [2*DATA_WIDTH-1:0] result_out,
    output logic                    out_is_write,
    output logic [CW-1:0]           outstanding,
    output logic                    protocol_err
);
    localparam int EW = 1 + BW + 4 + CID_WIDTH;

    logic [EW-1:0]           trk_q [DEPTH];
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    req_valid_q, req_valid_d, out_valid_q, out_valid_d, err_q, err_d;
    logic                    req_write_q, out_is_write_q;
    logic [HANDLE_WIDTH-1:0] req_handle_q;
    logic [DATA_WIDTH-1:0]   req_a_q, req_b_q;
    logic [BW-1:0]           block_q;
    logic [3:0]              dest_q;
    logic [CID_WIDTH-1:0]    cid_q;
    logic [2*DATA_WIDTH-1:0] result_q, ext;
    logic [EW-1:0]           head;
    logic                    head_w, out_free, acc, fire, load;

    always_comb begin
        head        = trk_q[rd_q];
        head_w      = head[EW-1];
        out_free    = !out_valid_q || out_ready;
        in_ready    = enable && (!req_valid_q || req_ready) && (cnt_q < CW'(DEPTH));
        // silent write acks never need the output stage
        rsp_ready   = enable && (cnt_q != '0) && ((head_w && !WRITE_ACK_OUT) || out_free);
        acc         = in_valid && in_ready;
        fire        = rsp_valid && rsp_ready;
        load        = fire && (!head_w || WRITE_ACK_OUT);
        ext         = SIGN_EXTEND ? {{DATA_WIDTH{rsp_data[DATA_WIDTH-1]}}, rsp_data}
                                  : {{DATA_WIDTH{1'b0}}, rsp_data};
        req_valid_d = !enable ? req_valid_q : acc ? 1'b1 : req_ready ? 1'b0 : req_valid_q;
        out_valid_d = !enable ? out_valid_q : load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        cnt_d       = cnt_q + CW'(acc) - CW'(fire);
        err_d       = err_q || (enable && rsp_valid && cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            wr_q           <= '0;
            rd_q           <= '0;
            req_write_q    <= 1'b0;
            req_handle_q   <= '0;
            req_a_q        <= '0;
            req_b_q        <= '0;
            block_q        <= '0;
            dest_q         <= '0;
            cid_q          <= '0;
            result_q       <= '0;
            out_is_write_q <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            if (acc) begin
                req_write_q  <= write_in;
                req_handle_q <= handle_in;
                req_a_q      <= arg_a_in;
                req_b_q      <= arg_b_in;
                trk_q[wr_q]  <= {write_in, block_in, dest_in, commit_id_in};
                wr_q         <= wr_q + 1'b1;
            end
            if (fire)
                rd_q <= rd_q + 1'b1;
            if (load) begin
                result_q       <= head_w ? '0 : ext;
                out_is_write_q <= head_w;
                block_q        <= head[EW-2 -: BW];
                dest_q         <= head[CID_WIDTH+3 -: 4];
                cid_q          <= head[CID_WIDTH-1:0];
            end
        end
    end

    assign req_valid     = req_valid_q;
    assign req_write     = req_write_q;
    assign req_handle    = req_handle_q;
    assign req_arg_a     = req_a_q;
    assign req_arg_b     = req_b_q;
    assign out_valid     = out_valid_q;
    assign block_out     = block_q;
    assign dest_out      = dest_q;
    assign commit_id_out = cid_q;
    assign result_out    = result_q;
    assign out_is_write  = out_is_write_q;
    assign outstanding   = cnt_q;
    assign protocol_err  = err_q;
endmodule

// File: doc/resource_branch_mo.md
Name: resource_branch_mo

Overview:
- Multi-outstanding successor to the single-request resource branch.
- Accepts resource read/write instructions from the core dispatch stage and issues them to an external resource port (delay lines, LUT memories).
- Tracks up to DEPTH in-flight requests whose responses return in issue order.
- Returns read results, and optionally write completions, to the commit path with their block/dest/commit_id tags.

Parameters:
- DATA_WIDTH, 16, width of args and response data
- HANDLE_WIDTH, 8, resource handle width
- N_BLOCKS, 256, block count; block tag width BW = clog2(N_BLOCKS)
- DEPTH, 4, maximum outstanding requests (power of 2, >=2)
- CID_WIDTH, 8, commit id width
- SIGN_EXTEND, 1, 1: result sign-extended to 2*DATA_WIDTH; 0: zero-extended
- WRITE_ACK_OUT, 0, 1: write completions also produce an output beat, with result 0

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  global pipeline advance; 0 freezes all state
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- write_in  in  1  1 = write, 0 = read
- block_in  in  BW  block tag
- handle_in  in  HANDLE_WIDTH  resource handle
- arg_a_in, arg_b_in  in  DATA_WIDTH  request arguments
- dest_in  in  4  destination register
- commit_id_in  in  CID_WIDTH  commit id
- req_valid  out  1  request to resource
- req_ready  in  1  resource accepts request
- req_write  out  1  request type
- req_handle  out  HANDLE_WIDTH  handle
- req_arg_a, req_arg_b  out  DATA_WIDTH  arguments
- rsp_valid  in  1  in-order response (read data or write ack)
- rsp_ready  out  1  response consumed when rsp_valid&&rsp_ready
- rsp_data  in  DATA_WIDTH  read data (ignored for writes)
- out_valid  out  1  result beat valid
- out_ready  in  1  commit path accepts
- block_out  out  BW  tag of the returning request
- dest_out  out  4  tag of the returning request
- commit_id_out  out  CID_WIDTH  tag of the returning request
- result_out  out  2*DATA_WIDTH  extended read data
- out_is_write  out  1  beat is a write completion
- outstanding  out  clog2(DEPTH)+1  tracker occupancy
- protocol_err  out  1  sticky: response arrived with empty tracker

Behaviour:
- Reset: all outputs 0, including req_valid, out_valid, outstanding and protocol_err. Tracker and request register are emptied, and in-flight requests are discarded. Reset overrides enable.
- enable=0: no register changes; in_ready=0 and rsp_ready=0; req_valid, out_valid and all payloads hold their values.
- Request register holds one request.
  - in_ready = enable && (!req_valid || req_ready) && (outstanding < DEPTH).
  - Accept: registers handle/args/write into req_* and sets req_valid the next cycle.
  - Accept also pushes {write, block, dest, commit_id} into the tracker FIFO.
  - req_valid stays 1 with stable payload until req_ready.
  - Back-to-back accepts yield 1 req per cycle while req_ready=1.
- Tracker: circular FIFO of DEPTH entries; outstanding counts entries from accept until response retire.
- Output stage is free when !out_valid || out_ready.
- rsp_ready = enable && outstanding>0 && (head is write && !WRITE_ACK_OUT ? 1 : output stage free).
- Response fire pops the head.
  - Read: loads result_out = extend(rsp_data), the head tags, out_is_write=0, and sets out_valid next cycle.
  - Write with WRITE_ACK_OUT=1: loads result_out=0 and out_is_write=1.
  - Write with WRITE_ACK_OUT=0: retires silently; out_valid is unaffected.
- out_valid clears on out_ready unless a new beat loads in the same cycle. Back-to-back beats are allowed.
- Latency: accept to req_valid is 1 cycle; rsp fire to out_valid is 1 cycle.
- Accept and response in the same cycle: outstanding unchanged; FIFO push and pop both performed.
- Full (outstanding==DEPTH): in_ready=0. A retire in that cycle does not open in_ready until the next cycle; in_ready is based on the registered count.
- rsp_valid with outstanding==0 (and enable=1): response ignored; protocol_err set, held until reset.
- Pointer wrap at DEPTH is modulo; no bubble on wrap.

Test Plan:
- Single read (DEPTH=4): handle=0x12, dest=3, cid=7, rsp_data=0x8001 one cycle after req fire -> one beat: result_out=0xFFFF8001, dest_out=3, commit_id_out=7, out_is_write=0.
- SIGN_EXTEND=0 with the same stimulus -> result_out=0x00008001.
- Four reads issued back-to-back with req_ready=1 and no responses -> outstanding reaches 4 and in_ready=0. Fifth request stalls until the first response, then is accepted on the following cycle. Four results emerge in issue order with cids 1,2,3,4.
- Interleaved write(cid=5) and read(cid=6), both acked: WRITE_ACK_OUT=0 -> single beat, cid=6. WRITE_ACK_OUT=1 -> two beats: cid=5 with out_is_write=1 and result 0, then cid=6.
- out_ready=0 for 10 cycles with 3 read responses pending -> rsp_ready=0 after the first beat loads. No beat is lost or reordered once out_ready=1.
- enable=0 mid-burst freezes all outputs and the count. Reset with 2 outstanding -> outstanding=0 and req_valid=0. A later rsp_valid sets protocol_err=1.
